// File: rtl/qbert_arb_pkg.sv
// rtl/qbert_arb_pkg.sv - shared types and defaults for the Q*bert memory arbiter
package qbert_arb_pkg;

    localparam int QBERT_MEM_ADDR_W = 13;
    localparam int QBERT_MEM_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    typedef logic port_idx_t;

    function automatic arb_state_t own_state(input port_idx_t p);
        return p ? OWN1 : OWN0;
    endfunction

endpackage

// File: rtl/qbert_rr_pick.sv
// rtl/qbert_rr_pick.sv - two-way round-robin winner select
module qbert_rr_pick
    import qbert_arb_pkg::*;
(
    input  logic      i_req0,
    input  logic      i_req1,
    input  port_idx_t i_last_owner,
    output port_idx_t o_winner,
    output logic      o_any
);

    always_comb begin
        o_any = i_req0 | i_req1;
        if (i_req0 && i_req1) begin
            o_winner = ~i_last_owner;
        end else begin
            o_winner = i_req1;
        end
    end

endmodule

// File: rtl/qbert_mem_arbiter.sv
// rtl/qbert_mem_arbiter.sv - Nios/sprite-fetch arbiter for the shared on-chip memory
// Optional owner lock enabled by defining QBERT_ARB_LOCK_EN.
module qbert_mem_arbiter
    import qbert_arb_pkg::*;
#(
    parameter int ADDR_W   = QBERT_MEM_ADDR_W,
    parameter int DATA_W   = QBERT_MEM_DATA_W,
    parameter int MAX_HOLD = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [ADDR_W-1:0]   m0_address,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W-1:0]   m0_writedata,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,
    input  logic [ADDR_W-1:0]   m1_address,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W-1:0]   m1_writedata,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,
`ifdef QBERT_ARB_LOCK_EN
    input  logic                m0_lock,
    input  logic                m1_lock,
`endif
    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic [DATA_W-1:0]   mem_writedata,
    output logic                mem_chipselect,
    output logic                mem_write,
    input  logic [DATA_W-1:0]   mem_readdata
);

    localparam int HC_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(MAX_HOLD - 1);

    arb_state_t      r_state, w_state_nxt;
    logic [HC_W-1:0] r_hold_cnt, w_hold_nxt;
    port_idx_t       r_last_owner, w_last_nxt;
    logic            r_rdv0, r_rdv1;

    logic      w_req0, w_req1, w_owned, w_own_req, w_oth_req, w_accept, w_lock, w_any;
    port_idx_t w_owner, w_pick_last, w_winner;

    assign w_req0      = m0_read | m0_write;
    assign w_req1      = m1_read | m1_write;
    assign w_owned     = (r_state != IDLE);
    assign w_owner     = (r_state == OWN1);
    assign w_own_req   = w_owner ? w_req1 : w_req0;
    assign w_oth_req   = w_owner ? w_req0 : w_req1;
    assign w_accept    = w_owned & w_own_req;
    // While owning, picking with last_owner = current owner yields the other port on handover.
    assign w_pick_last = w_owned ? w_owner : r_last_owner;

`ifdef QBERT_ARB_LOCK_EN
    assign w_lock = w_owned & (w_owner ? m1_lock : m0_lock);
`else
    assign w_lock = 1'b0;
`endif

    qbert_rr_pick u_pick (
        .i_req0       (w_req0),
        .i_req1       (w_req1),
        .i_last_owner (w_pick_last),
        .o_winner     (w_winner),
        .o_any        (w_any)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold_cnt;
        w_last_nxt  = r_last_owner;
        if (r_state == IDLE) begin
            if (w_any) begin
                w_state_nxt = own_state(w_winner);
            end
        end else begin
            if (w_accept && (r_hold_cnt != HOLD_LAST)) begin
                w_hold_nxt = r_hold_cnt + HC_W'(1);
            end
            if (!w_lock && (!w_own_req ||
                            (w_accept && (r_hold_cnt == HOLD_LAST) && w_oth_req))) begin
                w_last_nxt  = w_owner;
                w_hold_nxt  = '0;
                w_state_nxt = w_any ? own_state(w_winner) : IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_hold_cnt   <= '0;
            r_last_owner <= 1'b1;
            r_rdv0       <= 1'b0;
            r_rdv1       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_hold_cnt   <= w_hold_nxt;
            r_last_owner <= w_last_nxt;
            r_rdv0       <= w_accept & ~w_owner & m0_read;
            r_rdv1       <= w_accept & w_owner & m1_read;
        end
    end

    assign mem_address    = w_owner ? m1_address    : m0_address;
    assign mem_byteenable = w_owner ? m1_byteenable : m0_byteenable;
    assign mem_writedata  = w_owner ? m1_writedata  : m0_writedata;
    assign mem_chipselect = w_accept;
    assign mem_write      = w_accept & (w_owner ? m1_write : m0_write);

    assign m0_waitrequest   = w_req0 & (r_state != OWN0);
    assign m1_waitrequest   = w_req1 & (r_state != OWN1);
    assign m0_readdata      = mem_readdata;
    assign m1_readdata      = mem_readdata;
    assign m0_readdatavalid = r_rdv0;
    assign m1_readdatavalid = r_rdv1;

endmodule

// File: doc/qbert_mem_arbiter.md
# qbert_mem_arbiter

Two-requester arbiter that shares the single-port 32-bit on-chip memory (13-bit word address, byte enables, one-cycle read latency) between the Nios II data master (port 0) and the Q*bert sprite/tile fetcher (port 1). It sits between the two Avalon-MM masters and the memory's s1 slave port. It drives chip-select, write and byte-enable from the current owner, stalls the other requester with waitrequest, and tags returning read data with readdatavalid. Ownership is round-robin, with a bounded hold so that neither master can starve the other.

## Interface
- ADDR_W, 13, word address width (matches memory)
- DATA_W, 32, data width; byte-enable width is DATA_W/8
- MAX_HOLD, 4, maximum consecutive accepted transfers per ownership while the other port waits (≥1)
- clk  in  1  single clock; all logic rising-edge
- reset_n  in  1  asynchronous, active-low reset
- mN_address  in  ADDR_W  requester N address (N = 0, 1)
- mN_byteenable  in  DATA_W/8  byte enables
- mN_read / mN_write  in  1  command strobes; both high at once is illegal
- mN_writedata  in  DATA_W  write data
- mN_waitrequest  out  1  command not accepted this cycle
- mN_readdata  out  DATA_W  read data, valid when mN_readdatavalid=1
- mN_readdatavalid  out  1  one-cycle pulse per accepted read
- mem_address  out  ADDR_W; mem_byteenable  out  DATA_W/8; mem_writedata  out  DATA_W
- mem_chipselect / mem_write  out  1  to memory slave
- mem_readdata  in  DATA_W  memory output, valid the cycle after a read is presented

## Operation
- States: IDLE, OWN0, OWN1. Reset value is IDLE, with hold_cnt=0, last_owner=1 (port 0 wins the first tie), readdatavalid regs=0.
- reqN = mN_read | mN_write.
- IDLE: no grant; mN_waitrequest=reqN; mem_chipselect=0. Next state:
  - only one port requesting → OWN of that port;
  - both requesting → OWN of the port ≠ last_owner.
- OWNx:
  - mem_* are driven from port x; mem_chipselect=reqx; mem_write=mx_write.
  - mx_waitrequest=0; the other port's waitrequest = its req.
  - accept = reqx. Each accept increments hold_cnt (saturating at MAX_HOLD-1).
- Leaving OWNx (evaluated each cycle; last_owner←x; hold_cnt←0):
  - reqx=0 and other requesting → OWN other;
  - reqx=0 and no request → IDLE;
  - accept with hold_cnt==MAX_HOLD-1 and other requesting → OWN other;
  - otherwise stay.
- The grant switches with no idle cycle in between.
- Read return: an accepted read from x sets rdv_x, registered for one cycle. mx_readdatavalid=rdv_x. Both mN_readdata are driven from mem_readdata.
- Writes produce no response.
- Byte enables pass unchanged; the arbiter does no address arithmetic and does no range checking.
- Asynchronous reset mid-read: the pending readdatavalid is dropped; the master must reissue.

## Timing
- Arbitration from IDLE costs 1 cycle: a request in cycle T is accepted in T+1.
- Once owner, a port gets one accept per cycle; read data and readdatavalid arrive in the cycle after acceptance.
- Back-to-back reads from the same owner give readdatavalid high for consecutive cycles.
- Handover on hold expiry: the last accept of x is in cycle T, the first accept of the other port is in T+1, and x's readdatavalid from T is still delivered in T+1.
- A master must hold its command stable while waitrequest=1.

## Configuration
- QBERT_ARB_LOCK_EN defined: adds input mN_lock (1 bit).
  - While the owner has mN_lock=1, the hold limit is ignored.
  - The grant is also kept when reqx drops, so OWNx persists with no accepts. This supports atomic read-modify-write from Nios.
  - The lock is sampled only in OWNx.
- Not defined: no lock ports, and the hold rules above apply unconditionally.

## Structure
- Package qbert_arb_pkg holds:
  - the state enum (IDLE, OWN0, OWN1);
  - the port-index type;
  - default parameter constants QBERT_MEM_ADDR_W=13 and QBERT_MEM_DATA_W=32.
- Sub-module qbert_rr_pick: combinational two-way round-robin choice from (req0, req1, last_owner) → winner. It is used in the IDLE and handover decisions.

## Test plan
- Single read: m0 reads addr 0x0010 from IDLE. Expected: waitrequest high 1 cycle, accept in T+1, m0_readdatavalid in T+2 with the preloaded value 0xDEADBEEF; m1 sees no valid.
- Byte write: m1 writes 0x11223344 to 0x1387 with byteenable=4'b0100, then reads it back. Expected: memory returns 0x00220000 from a zeroed word; mem_byteenable=4'b0100 during the write.
- Simultaneous requests from reset: both issue reads. Expected: port 0 granted first, then port 1.
- Hold limit: m0 issues continuous reads with MAX_HOLD=4 while m1 waits. Expected: exactly 4 m0 accepts, then m1 is accepted in the very next cycle.
- Reset mid-read: assert reset_n=0 in the cycle after a read accept. Expected: no readdatavalid pulse, state IDLE, all waitrequest equal to req.
- With QBERT_ARB_LOCK_EN: m0 holds lock for 8 accesses while m1 requests. Expected: m1 waitrequest stays high throughout and m1 is accepted 1 cycle after lock drops.
